// File: rtl/hbus_pkg.sv
// Shared definitions for the HyperBus PHY read-capture calibration logic:
// config field layout, sequencer states and default tuning constants.
package hbus_pkg;

   localparam int IDX_W    = 7;
   localparam int EDGE_BIT = 6;
   localparam int PHASE_HI = 5;
   localparam int PHASE_LO = 4;
   localparam int DELAY_HI = 3;
   localparam int DELAY_LO = 0;

   localparam logic [31:0] PATTERN_DEF = 32'hA55A_0FF0;
   localparam logic [3:0]  READS_DEF   = 4'd4;
   localparam logic [7:0]  SETTLE_DEF  = 8'd16;
   localparam logic [7:0]  TIMEOUT_DEF = 8'd255;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRCFG,
      S_SETTLE,
      S_RDREQ,
      S_EVAL,
      S_UPDATE,
      S_APPLY,
      S_DONE
   } state_t;

   // Pack a setting index {edge, phase, delay} into the PHY config byte.
   function automatic logic [7:0] mk_cfg(input logic [IDX_W-1:0] s);
      logic [7:0] c;
      c                    = '0;
      c[EDGE_BIT]          = s[6];
      c[PHASE_HI:PHASE_LO] = s[5:4];
      c[DELAY_HI:DELAY_LO] = s[3:0];
      return c;
   endfunction

endpackage

// File: rtl/hbus_phy_cal_if.sv
// Signal bundle between the calibration sequencer and its environment
// (start/result, PHY config port, controller calibration read port).
interface hbus_phy_cal_if;
   import hbus_pkg::*;

   logic             cal_start;
   logic             cal_busy;
   logic             cal_done;
   logic             cal_ok;
   logic [IDX_W-1:0] cal_best;
   logic [7:0]       cal_win_len;
   logic [7:0]       phy_cfg_wdata;
   logic [7:0]       phy_cfg_rdata;
   logic             phy_cfg_stb;
   logic             rd_req;
   logic             rd_ack;
   logic [31:0]      rd_data;

   modport master (
      input  cal_start, phy_cfg_rdata, rd_ack, rd_data,
      output cal_busy, cal_done, cal_ok, cal_best, cal_win_len,
      output phy_cfg_wdata, phy_cfg_stb, rd_req
   );

   modport slave (
      output cal_start, phy_cfg_rdata, rd_ack, rd_data,
      input  cal_busy, cal_done, cal_ok, cal_best, cal_win_len,
      input  phy_cfg_wdata, phy_cfg_stb, rd_req
   );

endinterface

// File: rtl/hbus_phy_cal.sv
// Read-capture calibration sequencer: sweeps all 128 capture settings,
// test-reads a known pattern at each, then programs the best window centre.
module hbus_phy_cal
   import hbus_pkg::*;
#(
   parameter logic [31:0] PATTERN         = PATTERN_DEF,
   parameter logic [3:0]  READS_PER_POINT = READS_DEF,
   parameter logic [7:0]  SETTLE_CYCLES   = SETTLE_DEF,
   parameter logic [7:0]  TIMEOUT_CYCLES  = TIMEOUT_DEF
) (
   input  logic           clk_1x,
   input  logic           rst_n,
   hbus_phy_cal_if.master bus
);

   state_t           r_state;
   state_t           w_nxt;
   logic [IDX_W-1:0] r_s;
   logic [7:0]       r_cnt;
   logic [3:0]       r_rd;
   logic             r_match;
   logic [7:0]       r_orig;
   logic [IDX_W-1:0] r_cur_start;
   logic [7:0]       r_cur_len;
   logic [IDX_W-1:0] r_best_start;
   logic [7:0]       r_best_len;
   logic             r_busy;
   logic             r_done;
   logic             r_ok;
   logic [IDX_W-1:0] r_best;
   logic [7:0]       r_win_len;
   logic             r_stb;
   logic             r_rd_req;

   logic             w_timeout;
   logic             w_last_rd;
   logic [7:0]       w_new_len;
   logic [IDX_W-1:0] w_new_start;
   logic [IDX_W-1:0] w_centre;
   logic [7:0]       w_apply_cfg;

   assign w_timeout   = (r_cnt == TIMEOUT_CYCLES - 8'd1);
   assign w_last_rd   = (r_rd == READS_PER_POINT - 4'd1);
   assign w_new_len   = r_cur_len + 8'd1;
   assign w_new_start = (r_cur_len == 8'd0) ? r_s : r_cur_start;
   assign w_centre    = r_best_start + IDX_W'((r_best_len - 8'd1) >> 1);
   assign w_apply_cfg = (r_best_len != 8'd0) ? mk_cfg(w_centre) : r_orig;

   assign bus.cal_busy      = r_busy;
   assign bus.cal_done      = r_done;
   assign bus.cal_ok        = r_ok;
   assign bus.cal_best      = r_best;
   assign bus.cal_win_len   = r_win_len;
   assign bus.phy_cfg_stb   = r_stb;
   assign bus.rd_req        = r_rd_req;
   assign bus.phy_cfg_wdata = (r_state == S_APPLY) ? w_apply_cfg
                                                   : mk_cfg(r_s);

   // State register.
   always_ff @(posedge clk_1x or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_nxt;
   end

   // Next-state decode; an ack wins over a same-cycle timeout.
   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         S_IDLE:   if (bus.cal_start) w_nxt = S_WRCFG;
         S_WRCFG:  w_nxt = S_SETTLE;
         S_SETTLE: if (r_cnt == SETTLE_CYCLES - 8'd1) w_nxt = S_RDREQ;
         S_RDREQ:  if (bus.rd_ack || w_timeout) w_nxt = S_EVAL;
         S_EVAL:   w_nxt = (r_match && !w_last_rd) ? S_RDREQ : S_UPDATE;
         S_UPDATE: w_nxt = (r_s == 7'd127) ? S_APPLY : S_WRCFG;
         S_APPLY:  w_nxt = S_DONE;
         S_DONE:   w_nxt = S_IDLE;
         default:  w_nxt = S_IDLE;
      endcase
   end

   // Sweep datapath: counters, read result, window tracking, final result.
   always_ff @(posedge clk_1x or negedge rst_n) begin
      if (!rst_n) begin
         r_s          <= '0;
         r_cnt        <= '0;
         r_rd         <= '0;
         r_match      <= 1'b0;
         r_orig       <= '0;
         r_cur_start  <= '0;
         r_cur_len    <= '0;
         r_best_start <= '0;
         r_best_len   <= '0;
         r_ok         <= 1'b0;
         r_best       <= '0;
         r_win_len    <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.cal_start) begin
                  r_orig       <= bus.phy_cfg_rdata;
                  r_ok         <= 1'b0;
                  r_cur_len    <= '0;
                  r_cur_start  <= '0;
                  r_best_len   <= '0;
                  r_best_start <= '0;
                  r_s          <= '0;
               end
            end
            S_WRCFG: r_cnt <= '0;
            S_SETTLE: begin
               r_cnt <= r_cnt + 8'd1;
               if (w_nxt == S_RDREQ) begin
                  r_cnt <= '0;
                  r_rd  <= '0;
               end
            end
            S_RDREQ: begin
               r_cnt   <= r_cnt + 8'd1;
               r_match <= bus.rd_ack && (bus.rd_data == PATTERN);
            end
            S_EVAL: begin
               r_cnt <= '0;
               r_rd  <= r_rd + 4'd1;
            end
            S_UPDATE: begin
               if (r_match) begin
                  r_cur_start <= w_new_start;
                  r_cur_len   <= w_new_len;
                  if (w_new_len > r_best_len) begin
                     r_best_len   <= w_new_len;
                     r_best_start <= w_new_start;
                  end
               end else begin
                  r_cur_len <= '0;
               end
               if (r_s != 7'd127) r_s <= r_s + 7'd1;
            end
            S_APPLY: begin
               r_ok      <= (r_best_len != 8'd0);
               r_best    <= (r_best_len != 8'd0) ? w_centre
                                                 : r_orig[IDX_W-1:0];
               r_win_len <= r_best_len;
            end
            default: ;
         endcase
      end
   end

   // Registered handshake/status outputs, derived from the next state.
   always_ff @(posedge clk_1x or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_stb    <= 1'b0;
         r_rd_req <= 1'b0;
      end else begin
         r_busy   <= (w_nxt != S_IDLE) && (w_nxt != S_DONE);
         r_done   <= (w_nxt == S_DONE);
         r_stb    <= (w_nxt == S_WRCFG) || (w_nxt == S_APPLY);
         r_rd_req <= (w_nxt == S_RDREQ);
      end
   end

endmodule

// File: tb/tb_hbus_phy_cal.sv
// Scoreboard bench for hbus_phy_cal: randomized memory responder,
// window-search reference model, and a monitor checking each sweep result.
module tb_hbus_phy_cal;

   localparam logic [31:0] PAT = 32'hA55A_0FF0;

   typedef struct {
      bit       ok;
      bit [6:0] best;
      bit [7:0] len;
      bit [7:0] cfg;
      int       stbs;
   } exp_t;

   logic clk_1x;
   logic rst_n;

   hbus_phy_cal_if bus();

   hbus_phy_cal dut (
      .clk_1x (clk_1x),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   int         n_cmp = 0;
   int         n_err = 0;
   exp_t       q[$];
   bit [127:0] pass_map;
   int         withhold_s = -1;
   bit [7:0]   cur_cfg = 0;
   bit [7:0]   last_cfg = 0;
   int         stb_cnt = 0;
   int         done_cnt = 0;
   int         rd_idx = 0;
   int         wt = 0;
   bit         req_prev = 0;
   bit         chk_gap = 0;
   int         hi_len = 0;
   int         lo_len = 0;

   initial clk_1x = 1'b0;
   always #5 clk_1x = ~clk_1x;

   task automatic chk(input string nm, input longint act, input longint req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   function automatic bit [127:0] rng(input int lo, input int hi);
      bit [127:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   // Longest run of passing settings (earliest wins), centre rounded down.
   function automatic exp_t model(input bit [127:0] pm, input bit [7:0] orig);
      exp_t e;
      int bl;
      int bs;
      int i;
      int j;
      int b;
      bl = 0;
      bs = 0;
      i = 0;
      while (i < 128) begin
         if (pm[i]) begin
            j = i;
            while (j < 128 && pm[j]) j++;
            if (j - i > bl) begin
               bl = j - i;
               bs = i;
            end
            i = j;
         end else begin
            i++;
         end
      end
      e.ok   = (bl > 0);
      e.len  = 8'(bl);
      e.stbs = 129;
      if (bl > 0) begin
         b      = bs + (bl - 1) / 2;
         e.best = 7'(b);
         e.cfg  = {1'b0, 7'(b)};
      end else begin
         e.best = orig[6:0];
         e.cfg  = orig;
      end
      return e;
   endfunction

   // Memory responder: random ack latency, pattern only on passing settings.
   always @(negedge clk_1x) begin
      bit [31:0] g;
      if (!rst_n) begin
         bus.rd_ack = 1'b0;
         wt = 0;
      end else begin
         if (bus.phy_cfg_stb) rd_idx = 0;
         if (bus.rd_ack) begin
            bus.rd_ack = 1'b0;
            rd_idx++;
         end else if (bus.rd_req) begin
            if (withhold_s != int'(cur_cfg[6:0])) begin
               if (wt == 0) begin
                  g = $urandom;
                  if (g == PAT) g = ~g;
                  bus.rd_ack = 1'b1;
                  if (pass_map[cur_cfg[6:0]])
                     bus.rd_data = PAT;
                  else if (rd_idx >= 3 || $urandom_range(0, 1) == 1)
                     bus.rd_data = g;
                  else
                     bus.rd_data = PAT;
               end else begin
                  wt--;
               end
            end
         end else begin
            wt = $urandom_range(0, 3);
         end
      end
   end

   // Monitor: config writes, rd_req timing, and sweep results vs scoreboard.
   always @(negedge clk_1x) begin
      exp_t e;
      if (!rst_n) begin
         req_prev = 1'b0;
      end else begin
         if (bus.phy_cfg_stb) begin
            stb_cnt++;
            last_cfg = bus.phy_cfg_wdata;
            cur_cfg  = bus.phy_cfg_wdata;
         end
         if (bus.rd_req) begin
            if (!req_prev) begin
               if (chk_gap) begin
                  chk("after_timeout_cfg", cur_cfg, withhold_s + 1);
                  chk("after_timeout_gap", lo_len >= 17, 1);
                  chk_gap = 1'b0;
               end
               hi_len = 0;
            end
            hi_len++;
         end else begin
            if (req_prev) begin
               if (withhold_s >= 0 && withhold_s == int'(cur_cfg[6:0])) begin
                  chk("timeout_req_len", hi_len, 255);
                  chk_gap = 1'b1;
               end
               lo_len = 0;
            end
            lo_len++;
         end
         req_prev = bus.rd_req;
         if (bus.cal_done) begin
            done_cnt++;
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               e = q.pop_front();
               chk("cal_ok", bus.cal_ok, e.ok);
               chk("cal_best", bus.cal_best, e.best);
               chk("cal_win_len", bus.cal_win_len, e.len);
               chk("final_cfg", last_cfg, e.cfg);
               chk("stb_count", stb_cnt, e.stbs);
               chk("busy_at_done", bus.cal_busy, 0);
            end
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk_1x);
      bus.cal_start = 1'b1;
      @(negedge clk_1x);
      bus.cal_start = 1'b0;
   endtask

   task automatic run_sweep(input bit [127:0] pm, input bit [7:0] orig,
                            input bit poke);
      int d0;
      int n;
      pass_map          = pm;
      bus.phy_cfg_rdata = orig;
      q.push_back(model(pm, orig));
      stb_cnt = 0;
      d0 = done_cnt;
      pulse_start();
      chk("busy_after_start", bus.cal_busy, 1);
      if (poke) begin
         repeat (300) @(negedge clk_1x);
         pulse_start();
      end
      n = 0;
      while (done_cnt == d0 && n < 15000) begin
         @(negedge clk_1x);
         n++;
      end
      if (done_cnt == d0) begin
         chk("done_timeout", 0, 1);
         q.delete();
      end
      repeat (3) @(negedge clk_1x);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, bus.cal_busy, 0);
      chk({tag, "_done"}, bus.cal_done, 0);
      chk({tag, "_ok"}, bus.cal_ok, 0);
      chk({tag, "_best"}, bus.cal_best, 0);
      chk({tag, "_win_len"}, bus.cal_win_len, 0);
      chk({tag, "_stb"}, bus.phy_cfg_stb, 0);
      chk({tag, "_rd_req"}, bus.rd_req, 0);
      chk({tag, "_wdata"}, bus.phy_cfg_wdata, 0);
   endtask

   initial begin
      int n;
      int s0;
      bit [127:0] pm;
      rst_n             = 1'b0;
      bus.cal_start     = 1'b0;
      bus.phy_cfg_rdata = 8'h00;
      bus.rd_ack        = 1'b0;
      bus.rd_data       = 32'h0;
      pass_map          = '0;
      repeat (3) @(negedge clk_1x);
      chk_idle("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk_1x);

      run_sweep(rng(40, 52), 8'(($urandom)), 1'b1);
      run_sweep('0, 8'h15, 1'b0);
      run_sweep(rng(10, 14) | rng(100, 104), 8'h33, 1'b0);
      run_sweep(rng(120, 127), 8'h01, 1'b0);
      run_sweep(rng(0, 127), 8'h7f, 1'b0);

      withhold_s = 60;
      pm = rng(0, 127);
      pm[60] = 1'b0;
      run_sweep(pm, 8'h22, 1'b0);
      withhold_s = -1;

      pm = {$urandom, $urandom, $urandom, $urandom};
      run_sweep(pm, 8'(($urandom)), 1'b0);
      pm = {$urandom, $urandom, $urandom, $urandom}
         & {$urandom, $urandom, $urandom, $urandom};
      run_sweep(pm, 8'(($urandom)), 1'b0);

      pass_map          = rng(0, 127);
      bus.phy_cfg_rdata = 8'h44;
      pulse_start();
      n = 0;
      while (!(bus.rd_req && cur_cfg == 8'd30) && n < 5000) begin
         @(negedge clk_1x);
         n++;
      end
      chk("reached_s30_rdreq", bus.rd_req && cur_cfg == 8'd30, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_rd_req", bus.rd_req, 0);
      chk("rst_stb", bus.phy_cfg_stb, 0);
      chk("rst_busy", bus.cal_busy, 0);
      s0 = stb_cnt;
      repeat (5) @(negedge clk_1x);
      chk("no_stb_in_reset", stb_cnt, s0);
      rst_n = 1'b1;
      @(negedge clk_1x);
      chk("post_rst_busy", bus.cal_busy, 0);
      chk("post_rst_rd_req", bus.rd_req, 0);
      repeat (2) @(negedge clk_1x);
      run_sweep(rng(0, 127), 8'h44, 1'b0);

      chk("scoreboard_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
